sprite_cmd_encoder: RTL and testbench

//  Transmit side of the 32-bit sprite command bus consumed by the sprite display blocks.

---
 rtl/sprite_cmd_pkg.sv | 54 +++++
 rtl/sprite_req_fifo.sv | 63 ++++++
 rtl/sprite_cmd_encoder.sv | 168 ++++++++++++++++
 tb/tb_sprite_cmd_encoder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_cmd_pkg.sv
// Shared types, field positions and word packing for the sprite command bus.
package sprite_cmd_pkg;

    localparam logic [3:0] CTRL_NOP    = 4'h0;
    localparam logic [3:0] CTRL_UPDATE = 4'h1;
    localparam logic [3:0] CTRL_SWAP   = 4'hF;

    localparam logic [2:0] DT_NONE    = 3'b000;
    localparam logic [2:0] DT_PATTERN = 3'b001;
    localparam logic [2:0] DT_XPOS    = 3'b010;
    localparam logic [2:0] DT_YPOS    = 3'b011;

    localparam int COMP_LSB  = 26;
    localparam int COMP_W    = 6;
    localparam int CHILD_LSB = 21;
    localparam int CHILD_W   = 5;
    localparam int CTRL_LSB  = 17;
    localparam int CTRL_W    = 4;
    localparam int DTYPE_LSB = 14;
    localparam int DTYPE_W   = 3;
    localparam int BUF_LSB   = 13;
    localparam int MSG_LSB   = 0;
    localparam int MSG_W     = 13;

    typedef struct packed {
        logic [5:0] comp_id;
        logic [4:0] child;
        logic [4:0] pattern;
        logic       visible;
        logic       flip;
        logic [9:0] x;
        logic [9:0] y;
    } sprite_req_t;

    function automatic logic [31:0] pack_cmd(
        input logic [COMP_W-1:0]  comp,
        input logic [CHILD_W-1:0] child,
        input logic [CTRL_W-1:0]  ctrl,
        input logic [DTYPE_W-1:0] dtype,
        input logic               buf_sel,
        input logic [MSG_W-1:0]   msg
    );
        logic [31:0] w;
        w = '0;
        w[COMP_LSB  +: COMP_W]  = comp;
        w[CHILD_LSB +: CHILD_W] = child;
        w[CTRL_LSB  +: CTRL_W]  = ctrl;
        w[DTYPE_LSB +: DTYPE_W] = dtype;
        w[BUF_LSB]              = buf_sel;
        w[MSG_LSB   +: MSG_W]   = msg;
        return w;
    endfunction

endpackage

// File: rtl/sprite_req_fifo.sv
// Synchronous request queue; the popped entry is registered and held until the next pop.
module sprite_req_fifo
    import sprite_cmd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  sprite_req_t wr_data,
    input  logic        pop,
    output sprite_req_t rd_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    sprite_req_t mem_q [DEPTH];
    sprite_req_t mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    sprite_req_t rd_data_q, rd_data_d;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = rd_data_q;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/sprite_cmd_encoder.sv
// Encodes queued sprite updates into PATTERN/XPOS/YPOS words for the back buffer and
// issues a buffer-switch word once per frame at the raster swap point.
module sprite_cmd_encoder
    import sprite_cmd_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [9:0] SWAP_VCOUNT = 10'd480,
    parameter logic [9:0] SWAP_HCOUNT = 10'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_comp_id,
    input  logic [4:0]  req_child,
    input  logic [4:0]  req_pattern,
    input  logic        req_visible,
    input  logic        req_flip,
    input  logic [9:0]  req_x,
    input  logic [9:0]  req_y,
    output logic [31:0] writedata,
    output logic        word_valid,
    output logic        front_buf,
    output logic        frame_done
);

    // state | meaning
    // IDLE  | nothing in flight; pick switch, then next request
    // PAT   | emitting PATTERN word of the popped request
    // XPOS  | emitting XPOS word
    // YPOS  | emitting YPOS word, then choose next like IDLE
    // SWAP  | emitting switch word, flip front buffer
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PAT  = 3'd1;
    localparam logic [2:0] ST_XPOS = 3'd2;
    localparam logic [2:0] ST_YPOS = 3'd3;
    localparam logic [2:0] ST_SWAP = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        front_q, front_d;
    logic        pending_q, pending_d;
    logic [31:0] writedata_q, writedata_d;
    logic        word_valid_q, word_valid_d;
    logic        frame_done_q, frame_done_d;

    sprite_req_t req_in;
    sprite_req_t req_cur;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        fifo_push;
    logic        swap_hit;
    logic        take_next;
    logic        allow_swap;
    logic        upd_buf;
    logic [31:0] pat_word;
    logic [31:0] xpos_word;
    logic [31:0] ypos_word;
    logic [31:0] swap_word;

    assign req_in = '{comp_id: req_comp_id, child: req_child, pattern: req_pattern,
                      visible: req_visible, flip: req_flip, x: req_x, y: req_y};

    assign req_ready = ~fifo_full;
    assign fifo_push = req_valid & ~fifo_full;
    assign swap_hit  = (hcount == SWAP_HCOUNT) && (vcount == SWAP_VCOUNT);

    sprite_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (req_in),
        .pop     (fifo_pop),
        .rd_data (req_cur),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign upd_buf   = ~front_q;
    assign pat_word  = pack_cmd(req_cur.comp_id, req_cur.child, CTRL_UPDATE, DT_PATTERN, upd_buf,
                                {req_cur.visible, req_cur.flip, 6'd0, req_cur.pattern});
    assign xpos_word = pack_cmd(req_cur.comp_id, req_cur.child, CTRL_UPDATE, DT_XPOS, upd_buf,
                                {req_cur.visible, req_cur.flip, 1'b0, req_cur.x});
    assign ypos_word = pack_cmd(req_cur.comp_id, req_cur.child, CTRL_UPDATE, DT_YPOS, upd_buf,
                                {req_cur.visible, req_cur.flip, 1'b0, req_cur.y});
    assign swap_word = pack_cmd(6'd0, 5'd0, CTRL_SWAP, DT_NONE, ~front_q, 13'd0);

    always_comb begin
        state_d      = state_q;
        front_d      = front_q;
        pending_d    = pending_q | swap_hit;
        writedata_d  = '0;
        word_valid_d = 1'b0;
        frame_done_d = 1'b0;
        fifo_pop     = 1'b0;
        take_next    = 1'b0;
        allow_swap   = 1'b1;

        case (state_q)
            ST_IDLE: take_next = 1'b1;
            ST_PAT: begin
                writedata_d  = pat_word;
                word_valid_d = 1'b1;
                state_d      = ST_XPOS;
            end
            ST_XPOS: begin
                writedata_d  = xpos_word;
                word_valid_d = 1'b1;
                state_d      = ST_YPOS;
            end
            ST_YPOS: begin
                writedata_d  = ypos_word;
                word_valid_d = 1'b1;
                take_next    = 1'b1;
            end
            ST_SWAP: begin
                writedata_d  = swap_word;
                word_valid_d = 1'b1;
                frame_done_d = 1'b1;
                front_d      = ~front_q;
                // a trigger landing while the switch is going out is absorbed
                pending_d    = 1'b0;
                allow_swap   = 1'b0;
                take_next    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_next) begin
            if (allow_swap && (pending_q || swap_hit)) begin
                state_d = ST_SWAP;
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                state_d  = ST_PAT;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            front_q      <= 1'b0;
            pending_q    <= 1'b0;
            writedata_q  <= '0;
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            pending_q    <= pending_d;
            writedata_q  <= writedata_d;
            word_valid_q <= word_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign writedata  = writedata_q;
    assign word_valid = word_valid_q;
    assign front_buf  = front_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Self-checking bench for sprite_cmd_encoder: word scoreboard plus timed corner sequences.
module tb_sprite_cmd_encoder;

    typedef struct {
        logic [5:0]  comp;
        logic [4:0]  child;
        logic [4:0]  pat;
        logic        vis;
        logic        flip;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [31:0] e_pat;
        logic [31:0] e_x;
        logic [31:0] e_y;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        is_swap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  hcount = 10'd1;
    logic [9:0]  vcount = 10'd0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_comp_id = '0;
    logic [4:0]  req_child = '0;
    logic [4:0]  req_pattern = '0;
    logic        req_visible = 1'b0;
    logic        req_flip = 1'b0;
    logic [9:0]  req_x = '0;
    logic [9:0]  req_y = '0;
    logic [31:0] writedata;
    logic        word_valid;
    logic        front_buf;
    logic        frame_done;

    exp_t exp_q[$];
    vec_t tbl[4];
    int   errors = 0;
    int   checks = 0;
    logic front_m = 1'b0;

    always #5 clk = ~clk;

    sprite_cmd_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_comp_id (req_comp_id),
        .req_child   (req_child),
        .req_pattern (req_pattern),
        .req_visible (req_visible),
        .req_flip    (req_flip),
        .req_x       (req_x),
        .req_y       (req_y),
        .writedata   (writedata),
        .word_valid  (word_valid),
        .front_buf   (front_buf),
        .frame_done  (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [31:0] mword(input vec_t v, input logic b, input int k);
        logic [2:0]  dt;
        logic [12:0] msg;
        if (k == 0) begin
            dt  = 3'd1;
            msg = {v.vis, v.flip, 6'd0, v.pat};
        end else if (k == 1) begin
            dt  = 3'd2;
            msg = {v.vis, v.flip, 1'b0, v.x};
        end else begin
            dt  = 3'd3;
            msg = {v.vis, v.flip, 1'b0, v.y};
        end
        return {v.comp, v.child, 4'h1, dt, b, msg};
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v.comp  = 6'($urandom);
        v.child = 5'($urandom);
        v.pat   = 5'($urandom);
        v.vis   = 1'($urandom);
        v.flip  = 1'($urandom);
        v.x     = 10'($urandom);
        v.y     = 10'($urandom);
        v.e_pat = '0;
        v.e_x   = '0;
        v.e_y   = '0;
        return v;
    endfunction

    task automatic push_words(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        exp_q.push_back('{data: w0, is_swap: 1'b0});
        exp_q.push_back('{data: w1, is_swap: 1'b0});
        exp_q.push_back('{data: w2, is_swap: 1'b0});
    endtask

    task automatic push_model(input vec_t v, input logic b);
        push_words(mword(v, b, 0), mword(v, b, 1), mword(v, b, 2));
    endtask

    task automatic push_swap();
        logic [31:0] w;
        front_m = ~front_m;
        w       = 32'h001E_0000;
        w[13]   = front_m;
        exp_q.push_back('{data: w, is_swap: 1'b1});
    endtask

    // Starts and ends on a falling edge; holds the request until accepted.
    task automatic send(input vec_t v, output bit stalled);
        int n;
        n           = 0;
        stalled     = 1'b0;
        req_comp_id = v.comp;
        req_child   = v.child;
        req_pattern = v.pat;
        req_visible = v.vis;
        req_flip    = v.flip;
        req_x       = v.x;
        req_y       = v.y;
        req_valid   = 1'b1;
        while (req_ready !== 1'b1 && n < 100) begin
            stalled = 1'b1;
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            fail_now("req_accept");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic trigger_pulse(input logic [9:0] h, input logic [9:0] v, input int cycles);
        hcount = h;
        vcount = v;
        repeat (cycles) @(negedge clk);
        hcount = 10'd1;
        vcount = 10'd0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit   st;
        vec_t a;
        vec_t b;

        tbl[0] = '{6'd3,  5'd1,  5'd2,  1'b1, 1'b0, 10'd100,  10'd200,
                   32'h0C22_7002, 32'h0C22_B064, 32'h0C22_F0C8};
        tbl[1] = '{6'd63, 5'd31, 5'd31, 1'b1, 1'b1, 10'd1023, 10'd1023,
                   32'hFFE2_781F, 32'hFFE2_BBFF, 32'hFFE2_FBFF};
        tbl[2] = '{6'd0,  5'd0,  5'd0,  1'b0, 1'b0, 10'd0,    10'd0,
                   32'h0002_6000, 32'h0002_A000, 32'h0002_E000};
        tbl[3] = '{6'd42, 5'd17, 5'd21, 1'b0, 1'b1, 10'd513,  10'd7,
                   32'hAA22_6815, 32'hAA22_AA01, 32'hAA22_E807};

        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_writedata",  writedata, 32'd0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_front_buf",  32'(front_buf), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_req_ready",  32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (word_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%08h, expected no word", writedata);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", writedata, e.data);
                        check("frame_done", 32'(frame_done), 32'(e.is_swap));
                    end
                end else begin
                    check("idle_bus", {writedata[31:1], writedata[0] | frame_done}, 32'd0);
                end
            end
        join_none

        @(negedge clk);

        // T1: exact latency of the first request
        req_comp_id = tbl[0].comp;
        req_child   = tbl[0].child;
        req_pattern = tbl[0].pat;
        req_visible = tbl[0].vis;
        req_flip    = tbl[0].flip;
        req_x       = tbl[0].x;
        req_y       = tbl[0].y;
        req_valid   = 1'b1;
        push_words(tbl[0].e_pat, tbl[0].e_x, tbl[0].e_y);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("t1_lat_n0", writedata, 32'd0);
        @(negedge clk);
        check("t1_lat_n1", writedata, 32'd0);
        @(negedge clk);
        check("t1_pat", writedata, tbl[0].e_pat);
        check("t1_pat_valid", 32'(word_valid), 32'd1);
        @(negedge clk);
        check("t1_xpos", writedata, tbl[0].e_x);
        @(negedge clk);
        check("t1_ypos", writedata, tbl[0].e_y);
        @(negedge clk);
        check("t1_idle_after", writedata, 32'd0);
        wait_drain("t1_drain");

        for (int i = 1; i < 4; i++) begin
            push_words(tbl[i].e_pat, tbl[i].e_x, tbl[i].e_y);
            send(tbl[i], st);
            wait_drain("tbl_drain");
        end

        // T2: switch while idle, near-miss raster positions, held trigger
        push_swap();
        trigger_pulse(10'd0, 10'd480, 1);
        wait_drain("t2_drain_a");
        check("t2_front_1", 32'(front_buf), 32'd1);
        trigger_pulse(10'd0, 10'd479, 1);
        trigger_pulse(10'd1, 10'd480, 1);
        repeat (6) @(negedge clk);
        check("t2_nearmiss_front", 32'(front_buf), 32'd1);
        push_swap();
        trigger_pulse(10'd0, 10'd480, 2);
        wait_drain("t2_drain_b");
        check("t2_front_0", 32'(front_buf), 32'd0);

        // T3: trigger while XPOS of A is out; B queued behind and lands in new back buffer
        a = rnd_vec();
        b = rnd_vec();
        push_model(a, 1'b1);
        push_swap();
        push_model(b, 1'b0);
        send(a, st);
        send(b, st);
        @(negedge clk);
        @(negedge clk);
        check("t3_xpos_out", writedata, mword(a, 1'b1, 1));
        trigger_pulse(10'd0, 10'd480, 1);
        wait_drain("t3_drain");
        check("t3_front", 32'(front_buf), 32'd1);

        // T6: accept and trigger in the same cycle; switch goes first
        a = rnd_vec();
        push_swap();
        push_model(a, 1'b1);
        hcount = 10'd0;
        vcount = 10'd480;
        send(a, st);
        hcount = 10'd1;
        vcount = 10'd0;
        wait_drain("t6_drain");
        check("t6_front", 32'(front_buf), 32'd0);

        // T4: back-to-back pushes until the queue fills
        for (int i = 0; i < 13; i++) begin
            a = rnd_vec();
            push_model(a, 1'b1);
            send(a, st);
            if (i == 11) check("t4_full_ready", 32'(req_ready), 32'd0);
            if (i == 12) check("t4_stalled", 32'(st), 32'd1);
        end
        wait_drain("t4_drain");

        // T5: reset while a PATTERN word is out, with a second request queued
        push_swap();
        trigger_pulse(10'd0, 10'd480, 1);
        wait_drain("t5_pre_swap");
        a = rnd_vec();
        b = rnd_vec();
        exp_q.push_back('{data: mword(a, 1'b0, 0), is_swap: 1'b0});
        send(a, st);
        send(b, st);
        @(negedge clk);
        check("t5_pat_out", writedata, mword(a, 1'b0, 0));
        #2 reset = 1'b1;
        #1;
        check("t5_rst_writedata", writedata, 32'd0);
        check("t5_rst_front", 32'(front_buf), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd1);
        check("t5_pat_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        front_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_post_front", 32'(front_buf), 32'd0);
        check("t5_post_ready", 32'(req_ready), 32'd1);

        // after reset the front buffer is 0 again, so updates target buffer 1
        push_words(tbl[3].e_pat, tbl[3].e_x, tbl[3].e_y);
        send(tbl[3], st);
        wait_drain("t5_after_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
